buffer_memory_auto_addr: RTL and testbench



---
 rtl/buffer_memory_auto_addr_pkg.sv | 19 +
 rtl/buffer_memory_ram.sv | 41 ++++
 rtl/buffer_memory_auto_addr.sv | 69 ++++++
 tb/tb_buffer_memory_auto_addr.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/buffer_memory_auto_addr_pkg.sv
// Shared constants and helpers for the auto-addressed FIFO buffer and its RAM.
// Pointers carry one extra wrap bit above the memory address.
package buffer_memory_auto_addr_pkg;

    localparam int BUF_DATA_WIDTH = 32;
    localparam int BUF_ADDR_WIDTH = 4;
    localparam int BUF_PTR_WIDTH  = BUF_ADDR_WIDTH + 1;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Per-cycle accept decision, bundled so the top can pass both strobes together.
    typedef struct packed {
        logic wr;
        logic rd;
    } buf_accept_t;

endpackage

// File: rtl/buffer_memory_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
// Only the read register is reset; the storage array keeps its contents.
module buffer_memory_ram
    import buffer_memory_auto_addr_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write: a same-address write in this cycle is not visible here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/buffer_memory_auto_addr.sv
// Single-clock FIFO with internally generated addresses; holds the wrap-bit
// pointers, full/empty detection and the accept logic around a dual-port RAM.
module buffer_memory_auto_addr
    import buffer_memory_auto_addr_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_av
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] count_in;
    logic [PW-1:0] count_out;

    logic          w_empty;
    logic          w_full;
    buf_accept_t   w_acc;

    assign w_empty = (count_in == count_out);
    assign w_full  = (count_in[ADDR_WIDTH-1:0] == count_out[ADDR_WIDTH-1:0]) &&
                     (count_in[ADDR_WIDTH] != count_out[ADDR_WIDTH]);

    // Gating with !reset keeps X enables from reaching the RAM during reset.
    // A read frees a slot, so a write is still taken when full if a read goes too.
    always_comb begin
        w_acc    = '0;
        w_acc.rd = !reset && rd_en && !w_empty;
        w_acc.wr = !reset && wr_en && (!w_full || w_acc.rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_in  <= '0;
            count_out <= '0;
        end else begin
            if (w_acc.wr) begin
                count_in <= count_in + PW'(1);
            end
            if (w_acc.rd) begin
                count_out <= count_out + PW'(1);
            end
        end
    end

    buffer_memory_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_acc.wr),
        .i_wr_addr (count_in[ADDR_WIDTH-1:0]),
        .i_wr_data (data_in),
        .i_rd_en   (w_acc.rd),
        .i_rd_addr (count_out[ADDR_WIDTH-1:0]),
        .o_rd_data (data_out)
    );

    assign data_av = !w_empty;

endmodule

// File: tb/tb_buffer_memory_auto_addr.sv
// Directed bench: queue-based reference model checked every cycle, plus
// literal expectations at the key points of the stimulus.
module tb_buffer_memory_auto_addr;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_av;

    buffer_memory_auto_addr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_out (data_out),
        .data_av  (data_av)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: stored words in arrival order, pointer values, last read word.
    logic [DW-1:0] m_q[$];
    logic [AW:0]   m_in;
    logic [AW:0]   m_out;
    logic [DW-1:0] m_dout;
    bit            chk_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic we, input logic re,
                                input logic [DW-1:0] din);
        bit rd, wr;
        if (rst) begin
            m_q.delete();
            m_in   = '0;
            m_out  = '0;
            m_dout = '0;
        end else begin
            rd = re && (m_q.size() != 0);
            wr = we && ((m_q.size() < DEPTH) || rd);
            if (rd) begin
                m_dout = m_q.pop_front();
                m_out  = m_out + 1'b1;
            end
            if (wr) begin
                m_q.push_back(din);
                m_in = m_in + 1'b1;
            end
        end
    endtask

    // One clock cycle of stimulus; the model advances with the same sampled inputs.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [DW-1:0] din);
        reset   = rst;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        @(posedge clk);
        #1;
        model_update(rst, we, re, din);
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_av",   {31'd0, data_av}, {31'd0, (m_q.size() != 0)});
            chk("data_out",  data_out, m_dout);
            chk("count_in",  {27'd0, dut.count_in},  {27'd0, m_in});
            chk("count_out", {27'd0, dut.count_out}, {27'd0, m_out});
        end
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        m_in = '0; m_out = '0; m_dout = '0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset.av",   {31'd0, data_av}, 32'd0);
        chk("reset.dout", data_out, 32'd0);
        chk("reset.cin",  {27'd0, dut.count_in}, 32'd0);
        chk("reset.cout", {27'd0, dut.count_out}, 32'd0);

        // Read while empty is ignored.
        step(0, 0, 1, 0);
        chk("empty_rd.cout", {27'd0, dut.count_out}, 32'd0);

        step(0, 1, 0, 32'hAAAA_AAAA);
        chk("wr1.av", {31'd0, data_av}, 32'd1);
        step(0, 1, 0, 32'hBBBB_BBBB);
        chk("wr2.cin",  {27'd0, dut.count_in}, 32'd2);
        chk("wr2.cout", {27'd0, dut.count_out}, 32'd0);

        step(0, 1, 1, 32'hCCCC_CCCC);
        chk("rw1.dout", data_out, 32'hAAAA_AAAA);
        step(0, 1, 1, 32'hDDDD_DDDD);
        chk("rw2.dout", data_out, 32'hBBBB_BBBB);
        chk("rw2.cin",  {27'd0, dut.count_in}, 32'd4);
        chk("rw2.cout", {27'd0, dut.count_out}, 32'd2);

        step(0, 0, 1, 0);
        chk("rd1.dout", data_out, 32'hCCCC_CCCC);
        step(0, 0, 1, 0);
        chk("rd2.dout", data_out, 32'hDDDD_DDDD);
        chk("rd2.av",   {31'd0, data_av}, 32'd0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("rd4.dout", data_out, 32'hDDDD_DDDD);
        chk("rd4.cout", {27'd0, dut.count_out}, 32'd4);

        // Fill past depth: word 16 must be dropped.
        for (int i = 0; i < 17; i++) step(0, 1, 0, DW'(i));
        chk("full.cin", {27'd0, dut.count_in}, 32'd20);
        chk("full.av",  {31'd0, data_av}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            chk("drain.dout", data_out, DW'(i));
        end
        chk("drain.av", {31'd0, data_av}, 32'd0);

        // Empty read+write: only the write happens.
        step(0, 1, 1, 32'h1234_5678);
        chk("erw.dout", data_out, 32'd15);
        chk("erw.av",   {31'd0, data_av}, 32'd1);
        step(0, 0, 1, 0);
        chk("erw.rd",   data_out, 32'h1234_5678);

        // Refill, then read+write while full.
        for (int i = 0; i < 16; i++) step(0, 1, 0, 32'h100 + DW'(i));
        step(0, 1, 1, 32'h55);
        chk("fullrw.dout", data_out, 32'h100);
        chk("fullrw.cin",  {27'd0, dut.count_in}, 32'd6);
        chk("fullrw.cout", {27'd0, dut.count_out}, 32'd22);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("mid.dout", data_out, 32'h102);

        // Reset mid-stream with unknown enables.
        step(1, 1'bx, 1'bx, 32'hDEAD_BEEF);
        chk("rst.cin",  {27'd0, dut.count_in}, 32'd0);
        chk("rst.cout", {27'd0, dut.count_out}, 32'd0);
        chk("rst.av",   {31'd0, data_av}, 32'd0);
        chk("rst.dout", data_out, 32'd0);

        // Mixed traffic after reset, followed by a drain.
        for (int i = 0; i < 40; i++) begin
            step(0, (i % 3) != 2, (i % 4) == 1, 32'hA000 + DW'(i));
        end
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("final.av", {31'd0, data_av}, 32'd0);

        step(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
